// File: rtl/gcd_seq_pkg.sv
// Shared types and defaults for the GCD bus sequencer: state encoding,
// gpioemu register map and bus widths.
package gcd_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ADDR_W-1:0] A1_ADDR_DEF = 16'h00F8;
    localparam logic [ADDR_W-1:0] A2_ADDR_DEF = 16'h00FC;
    localparam logic [ADDR_W-1:0] W_ADDR_DEF  = 16'h0100;
    localparam logic [ADDR_W-1:0] S_ADDR_DEF  = 16'h0104;
    localparam int unsigned       DONE_BIT_DEF = 0;

    typedef enum logic [3:0] {
        IDLE,
        WR_A1,
        WR_A2,
        GAP,
        RD_S,
        S_WAIT,
        RD_W,
        W_WAIT,
        OUT
    } seq_state_e;

    // Address/data pair presented to the slave; held between strobes.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_req_t;

endpackage

// File: rtl/gcd_seq_wait_cnt.sv
// Loadable 8-bit down-counter; expired marks the last cycle of a wait of
// i_load_val cycles (load values are always >= 1).
module gcd_seq_wait_cnt
    import gcd_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired_c = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/gcd_bus_sequencer.sv
// Bus master that writes A1/A2 to gpioemu, polls S for done, reads W.
// Optional poll timeout: define GCD_SEQ_POLL_TIMEOUT_EN.
module gcd_bus_sequencer
    import gcd_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] A1_ADDR  = A1_ADDR_DEF,
    parameter logic [ADDR_W-1:0] A2_ADDR  = A2_ADDR_DEF,
    parameter logic [ADDR_W-1:0] W_ADDR   = W_ADDR_DEF,
    parameter logic [ADDR_W-1:0] S_ADDR   = S_ADDR_DEF,
    parameter int unsigned       DONE_BIT = DONE_BIT_DEF,
    parameter int unsigned       RD_LAT   = 1,
    parameter int unsigned       POLL_GAP = 4
`ifdef GCD_SEQ_POLL_TIMEOUT_EN
    ,
    parameter int unsigned       MAX_POLLS = 64
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_gcd,
    output logic              res_err,
    output logic              busy,
    output logic [ADDR_W-1:0] saddress,
    output logic              srd,
    output logic              swr,
    output logic [DATA_W-1:0] sdata_to_slv,
    input  logic [DATA_W-1:0] sdata_from_slv
);

    seq_state_e        r_state;
    bus_req_t          r_req;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_res_gcd;
    logic              r_op_ready;
    logic              r_res_valid;
    logic              r_busy;
    logic              r_srd;
    logic              r_swr;

    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_exp;
    logic              w_done;

    assign w_done = sdata_from_slv[DONE_BIT];

`ifdef GCD_SEQ_POLL_TIMEOUT_EN
    localparam int unsigned POLL_W = $clog2(MAX_POLLS + 1);

    logic [POLL_W-1:0] r_poll_cnt;
    logic              r_res_err;
    logic              w_poll_limit;

    assign w_poll_limit = (r_poll_cnt >= POLL_W'(MAX_POLLS));
    assign res_err      = r_res_err;
`else
    assign res_err = 1'b0;
`endif

    // Counter is reloaded on the cycle leaving each state that starts a wait.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = CNT_W'(POLL_GAP);
        case (r_state)
            WR_A2:  w_cnt_load = 1'b1;
            RD_S,
            RD_W: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = CNT_W'(RD_LAT);
            end
            S_WAIT: w_cnt_load = w_cnt_exp && !w_done;
            default: ;
        endcase
    end

    gcd_seq_wait_cnt u_wait_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_cnt_load),
        .i_load_val  (w_cnt_val),
        .o_expired_c (w_cnt_exp)
    );

    // Outputs are set on the edge that enters a state, so they track it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_op_b      <= '0;
            r_res_gcd   <= '0;
            r_op_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_srd       <= 1'b0;
            r_swr       <= 1'b0;
`ifdef GCD_SEQ_POLL_TIMEOUT_EN
            r_poll_cnt  <= '0;
            r_res_err   <= 1'b0;
`endif
        end else begin
            r_srd <= 1'b0;
            r_swr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (op_valid && r_op_ready) begin
                        r_op_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (op_a == '0 || op_b == '0) begin
                            r_res_gcd   <= op_a | op_b;
                            r_res_valid <= 1'b1;
                            r_state     <= OUT;
                        end else begin
                            r_op_b     <= op_b;
                            r_swr      <= 1'b1;
                            r_req.addr <= A1_ADDR;
                            r_req.data <= op_a;
`ifdef GCD_SEQ_POLL_TIMEOUT_EN
                            r_poll_cnt <= '0;
`endif
                            r_state    <= WR_A1;
                        end
                    end
                end
                WR_A1: begin
                    r_swr      <= 1'b1;
                    r_req.addr <= A2_ADDR;
                    r_req.data <= r_op_b;
                    r_state    <= WR_A2;
                end
                WR_A2: r_state <= GAP;
                GAP: begin
                    if (w_cnt_exp) begin
                        r_srd      <= 1'b1;
                        r_req.addr <= S_ADDR;
`ifdef GCD_SEQ_POLL_TIMEOUT_EN
                        r_poll_cnt <= r_poll_cnt + POLL_W'(1);
`endif
                        r_state    <= RD_S;
                    end
                end
                RD_S: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_cnt_exp) begin
                        if (w_done) begin
                            r_srd      <= 1'b1;
                            r_req.addr <= W_ADDR;
                            r_state    <= RD_W;
                        end
`ifdef GCD_SEQ_POLL_TIMEOUT_EN
                        else if (w_poll_limit) begin
                            r_res_gcd   <= '0;
                            r_res_err   <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_state     <= OUT;
                        end
`endif
                        else begin
                            r_state <= GAP;
                        end
                    end
                end
                RD_W: r_state <= W_WAIT;
                W_WAIT: begin
                    if (w_cnt_exp) begin
                        r_res_gcd   <= sdata_from_slv;
                        r_res_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
`ifdef GCD_SEQ_POLL_TIMEOUT_EN
                        r_res_err   <= 1'b0;
`endif
                        r_busy      <= 1'b0;
                        r_op_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign op_ready     = r_op_ready;
    assign res_valid    = r_res_valid;
    assign res_gcd      = r_res_gcd;
    assign busy         = r_busy;
    assign saddress     = r_req.addr;
    assign sdata_to_slv = r_req.data;
    assign srd          = r_srd;
    assign swr          = r_swr;

endmodule

// File: tb/tb_gcd_bus_sequencer.sv
// Directed bench for gcd_bus_sequencer with a behavioural gpioemu slave.
module tb_gcd_bus_sequencer;

    localparam logic [15:0] A1 = 16'h00F8;
    localparam logic [15:0] A2 = 16'h00FC;
    localparam logic [15:0] WA = 16'h0100;
    localparam logic [15:0] SA = 16'h0104;
    localparam int          PERIOD = 6;

    logic        clk;
    logic        reset;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;
    logic        res_valid, res_ready, res_err, busy;
    logic [31:0] res_gcd;
    logic [15:0] saddress;
    logic        srd, swr;
    logic [31:0] sdata_to_slv, sdata_from_slv;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int both_cnt = 0;
    int not_done = 0;
    int s_reads  = 0;
    logic [31:0] slv_a1, slv_a2;

    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];

    gcd_bus_sequencer #(
        .POLL_GAP (4)
`ifdef GCD_SEQ_POLL_TIMEOUT_EN
        ,
        .MAX_POLLS(4)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_a           (op_a),
        .op_b           (op_b),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_gcd        (res_gcd),
        .res_err        (res_err),
        .busy           (busy),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_to_slv   (sdata_to_slv),
        .sdata_from_slv (sdata_from_slv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] gcd_f(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // gpioemu slave: read data appears the cycle after the srd pulse.
    always @(posedge clk) begin
        if (swr) begin
            if (saddress == A1) begin
                slv_a1  = sdata_to_slv;
                s_reads = 0;
            end
            if (saddress == A2) slv_a2 = sdata_to_slv;
        end
        if (srd && saddress == SA) begin
            sdata_from_slv <= {31'd0, (s_reads >= not_done)};
            s_reads = s_reads + 1;
        end else if (srd && saddress == WA) begin
            sdata_from_slv <= gcd_f(slv_a1, slv_a2);
        end else begin
            sdata_from_slv <= 32'hDEADBEE0;
        end
    end

    always @(negedge clk) begin
        if (swr) begin
            wr_addr_q.push_back(saddress);
            wr_data_q.push_back(sdata_to_slv);
        end
        if (srd) begin
            rd_addr_q.push_back(saddress);
            rd_cyc_q.push_back(cyc);
        end
        if (swr && srd) both_cnt = both_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int nd, input logic [31:0] exp_g, input logic exp_err,
                          input int exp_lat, input int exp_sreads);
        int  wr0, rd0, c0, ns, nw, gaps_bad, last_s;
        bit  got;
        wr0 = wr_addr_q.size();
        rd0 = rd_addr_q.size();
        not_done = nd;
        c0 = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            if (op_ready) begin
                got = 1;
                c0  = cyc;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_accept"}, 32'(got), 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            if (res_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_res_valid"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(cyc - c0), 32'(exp_lat));
        check({tag, "_gcd"}, res_gcd, exp_g);
        check({tag, "_err"}, 32'(res_err), 32'(exp_err));
        ns = 0;
        nw = 0;
        gaps_bad = 0;
        last_s = -1;
        for (int i = rd0; i < rd_addr_q.size(); i++) begin
            if (rd_addr_q[i] == SA) begin
                if (last_s >= 0 && rd_cyc_q[i] - last_s != PERIOD) gaps_bad++;
                last_s = rd_cyc_q[i];
                ns++;
            end else if (rd_addr_q[i] == WA) begin
                nw++;
            end
        end
        check({tag, "_s_reads"}, 32'(ns), 32'(exp_sreads));
        check({tag, "_w_reads"}, 32'(nw), (exp_sreads > 0 && !exp_err) ? 32'd1 : 32'd0);
        check({tag, "_writes"}, 32'(wr_addr_q.size() - wr0), (exp_sreads > 0) ? 32'd2 : 32'd0);
        if (exp_sreads > 1) check({tag, "_poll_spacing"}, 32'(gaps_bad), 32'd0);
        if (exp_sreads > 0 && wr_addr_q.size() >= wr0 + 2) begin
            check({tag, "_wr0"}, {wr_addr_q[wr0], wr_data_q[wr0][15:0]}, {A1, a[15:0]});
            check({tag, "_wr1"}, {wr_addr_q[wr0+1], wr_data_q[wr0+1][15:0]}, {A2, b[15:0]});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_post_err"}, 32'(res_err), 32'd0);
        check({tag, "_post_ready"}, 32'(op_ready), 32'd1);
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          nd;
        logic [31:0] g;
        int          lat;
        int          sreads;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit got;
        vecs[0] = '{32'd39,  32'd9,  0, 32'd3,  11, 1};
        vecs[1] = '{32'd48,  32'd18, 3, 32'd6,  29, 4};
        vecs[2] = '{32'd0,   32'd7,  0, 32'd7,  1,  0};
        vecs[3] = '{32'd0,   32'd0,  0, 32'd0,  1,  0};
        vecs[4] = '{32'd100, 32'd75, 1, 32'd25, 17, 2};
        vecs[5] = '{32'd7,   32'd0,  0, 32'd7,  1,  0};
        vecs[6] = '{32'd17,  32'd5,  0, 32'd1,  11, 1};
        vecs[7] = '{32'd13,  32'd13, 2, 32'd13, 23, 3};

        reset = 1'b1;
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", {30'd0, srd, swr}, 32'd0);
        check("rst_addr", 32'(saddress), 32'd0);
        check("rst_gcd", res_gcd, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_op_ready", 32'(op_ready), 32'd1);

        // res_ready before res_valid must not matter
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].nd,
                   vecs[i].g, 1'b0, vecs[i].lat, vecs[i].sreads);
        end

        // Backpressure in OUT with a second operand pair waiting.
        not_done = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a = 32'd39;
        op_b = 32'd9;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            if (op_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        op_a = 32'd0;
        op_b = 32'd5;
        for (int i = 0; i < 400 && !res_valid; i++) @(negedge clk);
        check("bp_first_valid", 32'(res_valid & got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_gcd", res_gcd, 32'd3);
            check("bp_hold_op_ready", 32'(op_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_after_hs_valid", 32'(res_valid), 32'd0);
        check("bp_after_hs_ready", 32'(op_ready), 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        check("bp_second_valid", 32'(res_valid), 32'd1);
        check("bp_second_gcd", res_gcd, 32'd5);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset while waiting on a status read.
        not_done = 3;
        @(negedge clk);
        op_valid = 1'b1;
        op_a = 32'd48;
        op_b = 32'd18;
        for (int i = 0; i < 50 && !op_ready; i++) @(negedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (srd && saddress == SA) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("mid_rst_saw_poll", 32'(got), 32'd1);
        @(negedge clk);
        check("mid_rst_busy_before", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_strobes", {30'd0, srd, swr}, 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_addr", 32'(saddress), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_op_ready", 32'(op_ready), 32'd1);
        check("mid_rst_no_result", 32'(res_valid), 32'd0);
        run_op("after_rst", 32'd21, 32'd14, 0, 32'd7, 1'b0, 11, 1);

`ifdef GCD_SEQ_POLL_TIMEOUT_EN
        run_op("timeout", 32'd12, 32'd8, 1000, 32'd0, 1'b1, 27, 4);
`endif

        check("strobe_overlap", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
